// File: rtl/audio_out_pkg.sv
// Shared types and constants for the PDM audio sink.
// Dither constants are used only when AUDIO_PDM_DITHER_EN is defined.
package audio_out_pkg;

    typedef enum logic [1:0] {
        START,
        RUN,
        UNDERRUN
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] to_offset(
        input logic [31:0] s,
        input int          b
    );
        return s ^ (32'd1 << (b - 1));
    endfunction

endpackage

// File: rtl/audio_pdm_out_if.sv
// Valid-strobed signed sample stream into the PDM sink.
// No backpressure: the producer drives, the sink listens.
interface audio_pdm_out_if #(
    parameter int AUDIO_BDEPTH = 8
);
    logic signed [AUDIO_BDEPTH-1:0] audio_in;
    logic                           valid_in;

    modport master (output audio_in, valid_in);
    modport slave  (input  audio_in, valid_in);
endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with flush and registered read data.
// A write on a full FIFO is safe only together with a read.
module audio_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + AW'(1);
            if (rd_en) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/audio_pdm_out.sv
// FIFO-buffered audio sink driving a first-order sigma-delta PDM pin.
// Define AUDIO_PDM_DITHER_EN to add LFSR carry-in dither to the modulator.
module audio_pdm_out
    import audio_out_pkg::*;
#(
    parameter int AUDIO_BDEPTH = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int PREFILL      = 2,
    parameter int SAMPLE_DIV   = 101
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    audio_pdm_out_if.slave              bus,
    output logic                        pdm_out,
    output logic                        running,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underflow,
    output logic [7:0]                  underrun_count
);
    localparam int B  = AUDIO_BDEPTH;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0] FULL    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PRE     = LW'(PREFILL);

    state_t               state;
    logic [DW-1:0]        div;
    logic                 tick;
    logic                 pop;
    logic                 pop_q;
    logic                 wr;
    logic [LW-1:0]        level;
    logic signed [B-1:0]  rd_data;
    logic signed [B-1:0]  hold;
    logic signed [B-1:0]  hold_eff;
    logic [B-1:0]         u;
    logic [B-1:0]         acc;
    logic [B:0]           sum;
    logic                 cin;

    assign tick = enable && (div == '0);

    always_comb begin
        pop = 1'b0;
        if (tick) begin
            unique case (state)
                RUN:     pop = (level != '0);
                default: pop = (level >= PRE);
            endcase
        end
    end

    assign wr = enable && bus.valid_in && ((level != FULL) || pop);

    audio_sample_fifo #(
        .WIDTH (B),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (!enable),
        .wr_en   (wr),
        .wr_data (bus.audio_in),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (level)
    );

    assign fifo_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div            <= DIV_MAX;
            state          <= START;
            running        <= 1'b0;
            hold           <= '0;
            pop_q          <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            underrun_count <= '0;
        end else if (!enable) begin
            div       <= DIV_MAX;
            state     <= START;
            running   <= 1'b0;
            hold      <= '0;
            pop_q     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div       <= tick ? DIV_MAX : div - DW'(1);
            pop_q     <= pop;
            overflow  <= bus.valid_in && (level == FULL) && !pop;
            underflow <= 1'b0;
            if (pop_q)
                hold <= rd_data;
            if (tick) begin
                unique case (state)
                    RUN: if (!pop) begin
                        state     <= UNDERRUN;
                        running   <= 1'b0;
                        underflow <= 1'b1;
                        if (underrun_count != 8'hFF)
                            underrun_count <= underrun_count + 8'd1;
                    end
                    default: if (pop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Read data lands one clock after the pop; forward it so the
    // modulator sees the new sample on the clock after the tick.
    assign hold_eff = pop_q ? rd_data : hold;
    assign u        = B'(to_offset(32'(hold_eff), B));

`ifdef AUDIO_PDM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (!enable)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    assign sum = {1'b0, acc} + {1'b0, u} + {{B{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc     <= sum[B-1:0];
            pdm_out <= sum[B];
        end
    end

endmodule

// File: tb/tb_audio_pdm_out.sv
// Randomised bench for audio_pdm_out against a queue-based sample model.
// Directed blocks cover idle, density, overflow, underrun and reset cases.
module tb_audio_pdm_out;

    localparam int B     = 8;
    localparam int DEPTH = 4;
    localparam int PRE   = 2;
    localparam int DIV   = 101;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      enable;
    logic                      pdm_out;
    logic                      running;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic                      overflow;
    logic                      underflow;
    logic [7:0]                underrun_count;

    audio_pdm_out_if #(.AUDIO_BDEPTH(B)) bus ();

    audio_pdm_out #(
        .AUDIO_BDEPTH (B),
        .FIFO_DEPTH   (DEPTH),
        .PREFILL      (PRE),
        .SAMPLE_DIV   (DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .bus            (bus),
        .pdm_out        (pdm_out),
        .running        (running),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .underflow      (underflow),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // Reference model: sample queue, clocks since enable, play mode
    typedef enum {M_START, M_RUN, M_UNDER} mode_t;
    int    q[$];
    int    k;
    mode_t mode;
    int    hold_m;
    int    acc_m;
    int    pdm_m;
    int    ov_m;
    int    uf_m;
    int    cnt_m;

    task automatic mreset();
        q.delete();
        k      = 0;
        mode   = M_START;
        hold_m = 0;
        acc_m  = 0;
        pdm_m  = 0;
        ov_m   = 0;
        uf_m   = 0;
        cnt_m  = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input int smp);
        int  sum;
        int  lvl;
        bit  tk;
        bit  pp;
        sum   = acc_m + (hold_m + 2 ** (B - 1));
        pdm_m = sum / (2 ** B);
        acc_m = sum % (2 ** B);
        if (!en) begin
            q.delete();
            k      = 0;
            mode   = M_START;
            hold_m = 0;
            ov_m   = 0;
            uf_m   = 0;
        end else begin
            tk   = (k == DIV - 1);
            k    = tk ? 0 : k + 1;
            lvl  = q.size();
            pp   = 0;
            ov_m = 0;
            uf_m = 0;
            if (tk) begin
                if (mode == M_RUN) begin
                    if (lvl > 0) pp = 1;
                    else begin
                        uf_m = 1;
                        mode = M_UNDER;
                        if (cnt_m < 255) cnt_m++;
                    end
                end else if (lvl >= PRE) begin
                    pp   = 1;
                    mode = M_RUN;
                end
            end
            if (pp) hold_m = q.pop_front();
            if (v) begin
                if (lvl < DEPTH || pp) q.push_back(smp);
                else ov_m = 1;
            end
        end
    endtask

    task automatic cyc(input bit en, input bit v, input int smp);
        enable       = en;
        bus.valid_in = v;
        bus.audio_in = B'(smp);
        model_edge(en, v, smp);
        @(posedge clk);
        @(negedge clk);
        check("pdm", pdm_out, pdm_m);
        check("running", running, (mode == M_RUN) ? 1 : 0);
        check("level", fifo_level, q.size());
        check("overflow", overflow, ov_m);
        check("underflow", underflow, uf_m);
        check("urun_cnt", underrun_count, cnt_m);
    endtask

    task automatic wait_tick_next();
        int guard = 0;
        while (k != DIV - 1 && guard < 2 * DIV) begin
            cyc(1, 0, 0);
            guard++;
        end
        check("tick_wait", (k == DIV - 1) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_pdm"}, pdm_out, 0);
        check({tag, "_run"}, running, 0);
        check({tag, "_lvl"}, fifo_level, 0);
        check({tag, "_ov"}, overflow, 0);
        check({tag, "_uf"}, underflow, 0);
        check({tag, "_cnt"}, underrun_count, 0);
    endtask

    initial begin
        int ones;
        int ones2;
        int cnt;
        int runs;
        int base;
        int rate;

        rst          = 1'b1;
        enable       = 1'b0;
        bus.valid_in = 1'b0;
        bus.audio_in = '0;
        #2;
        check_reset_outs("reset");
        mreset();
        @(negedge clk);
        rst = 1'b0;

        // Idle: mid-scale alternation, no underflow
        ones = 0; cnt = 0; runs = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1, 0, 0);
            ones += pdm_out;
            cnt  += underflow;
            runs += running;
        end
        check("idle_ones", ones, 500);
        check("idle_uf", cnt, 0);
        check("idle_run", runs, 0);

        // Full negative then full positive
        cyc(0, 0, 0);
        cyc(1, 1, -128);
        cyc(1, 1, -128);
        for (int e = 3; e < 110; e++) cyc(1, 0, 0);
        check("neg_run", running, 1);
        ones = 0; ones2 = 0;
        for (int e = 110; e <= 700; e++) begin
            cyc(1, (e % DIV) == 50, 127);
            if (e <= 199) ones += pdm_out;
            if (e >= 400 && e <= 655) ones2 += pdm_out;
        end
        check("neg_ones", ones, 0);
        check("pos_ones256", ones2, 255);

        // Five writes back to back
        cyc(0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, i * 7 - 20);
            cnt += overflow;
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0);
            cnt += overflow;
        end
        check("ovf_pulses", cnt, 1);
        check("ovf_level", fifo_level, 4);

        // Write on a full FIFO in the same cycle as a tick pop
        wait_tick_next();
        cyc(1, 1, 33);
        check("full_pop_ov", overflow, 0);
        check("full_pop_lvl", fifo_level, 4);
        check("full_pop_run", running, 1);

        // Prefill two, starve, then refill
        cyc(0, 0, 0);
        base = cnt_m;
        cyc(1, 1, 10);
        cyc(1, 1, 64);
        cnt = 0;
        for (int e = 3; e <= 404; e++) begin
            cyc(1, 0, 0);
            cnt += underflow;
        end
        check("urun_pulses", cnt, 1);
        check("urun_count", underrun_count, base + 1);
        check("urun_run", running, 0);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1, 0, 0);
            ones += pdm_out;
        end
        check("urun_ones256", ones, 192);
        cyc(1, 1, 5);
        cyc(1, 1, 6);
        wait_tick_next();
        cyc(1, 0, 0);
        check("resume_run", running, 1);

        // Drop enable mid-RUN
        base = cnt_m;
        cyc(1, 1, 9);
        cyc(0, 0, 0);
        check("dis_level", fifo_level, 0);
        check("dis_run", running, 0);
        check("dis_cnt", underrun_count, base);

        // Random traffic at several producer rates
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: rate = 0;
                1: rate = 20;
                2: rate = 95;
                3: rate = 110;
                4: rate = 300;
                default: rate = 60;
            endcase
            for (int i = 0; i < 2500; i++)
                cyc($urandom_range(0, 999) != 0,
                    $urandom_range(0, rate) == 0,
                    int'($urandom_range(0, 255)) - 128);
        end

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outs("async_rst");
        mreset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1, i < 3, 40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
